rei_fetch: RTL and testbench

REI_FETCH -- requirements
Module: rei_fetch

---
 rtl/rei_pkg.sv | 19 +
 rtl/fetch_queue.sv | 70 +++++++
 rtl/rei_fetch.sv | 138 +++++++++++++
 tb/tb_rei_fetch.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rei_pkg.sv
// Shared widths, reset vector and queue entry type for the instruction fetch unit.
package rei_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned ILEN = 32;

   localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_1000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] ir;
   } fetch_entry_s;

   // Instructions are word aligned; misaligned restart targets are trapped elsewhere.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return pc & {{(XLEN-2){1'b1}}, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Power-of-two circular buffer with flush; used for fetched instructions and for
// the address tags of outstanding bus requests.
module fetch_queue
   import rei_pkg::*;
#(
   parameter int unsigned Depth   = 4,
   parameter type         entry_t = logic [31:0]
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic                  push_i,
   input  entry_t                data_i,
   input  logic                  pop_i,
   output entry_t                head_o,
   output logic [$clog2(Depth):0] count_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam logic [PtrW:0] FullCnt = (PtrW+1)'(Depth);

   entry_t          mem_r [Depth];
   logic [PtrW-1:0] rd_ptr_r;
   logic [PtrW-1:0] wr_ptr_r;
   logic [PtrW:0]   count_r;
   logic            do_push_s;
   logic            do_pop_s;

   // Qualify push/pop against flush, full and empty.
   always_comb begin
      do_push_s = push_i && !flush_i && (count_r != FullCnt);
      do_pop_s  = pop_i && !flush_i && (count_r != (PtrW+1)'(1'b0));
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk_i) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= data_i;
      end
   end

   // Pointers wrap naturally at Depth since Depth is a power of two.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr_r <= PtrW'(1'b0);
         wr_ptr_r <= PtrW'(1'b0);
         count_r  <= (PtrW+1)'(1'b0);
      end else if (flush_i) begin
         rd_ptr_r <= PtrW'(1'b0);
         wr_ptr_r <= PtrW'(1'b0);
         count_r  <= (PtrW+1)'(1'b0);
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PtrW'(1'b1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PtrW'(1'b1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + (PtrW+1)'(1'b1);
            2'b01:   count_r <= count_r - (PtrW+1)'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign head_o  = mem_r[rd_ptr_r];
   assign count_o = count_r;

endmodule

// File: rtl/rei_fetch.sv
// Instruction fetch front end: issues in-order ibus reads, queues responses for decode,
// and discards in-flight responses after a redirect. REI_FETCH_BYPASS_EN enables a
// zero-latency response-to-decode path when the queue is empty.
module rei_fetch
   import rei_pkg::*;
#(
   parameter int unsigned Depth          = 4,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic            clk_i,
   input  logic            rst_i,
   output logic            ibus_arvalid_o,
   input  logic            ibus_arready_i,
   output logic [XLEN-1:0] ibus_araddr_o,
   input  logic            ibus_rvalid_i,
   input  logic [ILEN-1:0] ibus_rdata_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [XLEN-1:0] pc_o,
   output logic [ILEN-1:0] ir_o
);

   localparam int unsigned CntW = $clog2(Depth) + 1;
   localparam logic [CntW-1:0] MaxOutC = CntW'(MaxOutstanding);
   localparam logic [CntW:0]   DepthC  = (CntW+1)'(Depth);

   logic [XLEN-1:0] fpc_r;
   logic [CntW-1:0] outst_r;
   logic [CntW-1:0] drop_cnt_r;
   logic [CntW-1:0] q_count_s;
   logic [CntW-1:0] tag_count_s;
   logic [CntW:0]   occupancy_s;
   logic [XLEN-1:0] tag_head_s;
   fetch_entry_s    q_head_s;
   fetch_entry_s    q_in_s;
   logic            req_hs_s;
   logic            rsp_seen_s;
   logic            resp_take_s;
   logic            bypass_s;
   logic            valid_s;
   logic            q_push_s;
   logic            q_pop_s;

   // Request gating, response classification and decode-side presentation.
   always_comb begin
      occupancy_s    = {1'b0, q_count_s} + {1'b0, outst_r};
      ibus_arvalid_o = !rst_i && !redirect_i && (outst_r < MaxOutC) && (occupancy_s < DepthC);
      req_hs_s       = ibus_arvalid_o && ibus_arready_i;
      rsp_seen_s     = ibus_rvalid_i && (outst_r != CntW'(1'b0));
      // A response with no tag waiting (e.g. from before a reset) is ignored.
      resp_take_s    = rsp_seen_s && !redirect_i && (drop_cnt_r == CntW'(1'b0))
                       && (tag_count_s != CntW'(1'b0));
`ifdef REI_FETCH_BYPASS_EN
      bypass_s       = resp_take_s && (q_count_s == CntW'(1'b0));
`else
      bypass_s       = 1'b0;
`endif
      valid_s        = !rst_i && !redirect_i && (bypass_s || (q_count_s != CntW'(1'b0)));
      q_push_s       = resp_take_s && !(bypass_s && ready_i);
      q_pop_s        = !redirect_i && ready_i && (q_count_s != CntW'(1'b0));
      q_in_s.pc      = tag_head_s;
      q_in_s.ir      = ibus_rdata_i;
      valid_o        = valid_s;
      if (bypass_s) begin
         pc_o = tag_head_s;
         ir_o = ibus_rdata_i;
      end else if (valid_s) begin
         pc_o = q_head_s.pc;
         ir_o = q_head_s.ir;
      end else begin
         pc_o = {XLEN{1'b0}};
         ir_o = {ILEN{1'b0}};
      end
   end

   assign ibus_araddr_o = fpc_r;

   // Fetch pc, outstanding-request count and post-redirect discard count.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fpc_r      <= RESET_VECTOR;
         outst_r    <= CntW'(1'b0);
         drop_cnt_r <= CntW'(1'b0);
      end else begin
         if (redirect_i) begin
            fpc_r <= align_pc(redirect_pc_i);
         end else if (req_hs_s) begin
            fpc_r <= fpc_r + XLEN'(3'd4);
         end else begin
            fpc_r <= fpc_r;
         end
         case ({req_hs_s, rsp_seen_s})
            2'b10:   outst_r <= outst_r + CntW'(1'b1);
            2'b01:   outst_r <= outst_r - CntW'(1'b1);
            default: outst_r <= outst_r;
         endcase
         // Everything still in flight at a redirect belongs to the old path.
         if (redirect_i) begin
            drop_cnt_r <= rsp_seen_s ? (outst_r - CntW'(1'b1)) : outst_r;
         end else if (rsp_seen_s && (drop_cnt_r != CntW'(1'b0))) begin
            drop_cnt_r <= drop_cnt_r - CntW'(1'b1);
         end else begin
            drop_cnt_r <= drop_cnt_r;
         end
      end
   end

   fetch_queue #(
      .Depth   (Depth),
      .entry_t (logic [XLEN-1:0])
   ) u_tag_q (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (redirect_i),
      .push_i  (req_hs_s),
      .data_i  (fpc_r),
      .pop_i   (resp_take_s),
      .head_o  (tag_head_s),
      .count_o (tag_count_s)
   );

   fetch_queue #(
      .Depth   (Depth),
      .entry_t (fetch_entry_s)
   ) u_inst_q (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (redirect_i),
      .push_i  (q_push_s),
      .data_i  (q_in_s),
      .pop_i   (q_pop_s),
      .head_o  (q_head_s),
      .count_o (q_count_s)
   );

endmodule

// File: tb/tb_rei_fetch.sv
// Directed bench for rei_fetch: in-order streaming, back-pressure, redirect draining
// and asynchronous reset, against a one-cycle-latency in-order bus responder.
module tb_rei_fetch;

   localparam logic [31:0] RV = 32'h0000_1000;
`ifdef REI_FETCH_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        ibus_arvalid;
   logic        ibus_arready;
   logic [31:0] ibus_araddr;
   logic        ibus_rvalid;
   logic [31:0] ibus_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        valid;
   logic        ready;
   logic [31:0] pc;
   logic [31:0] ir;

   int          total_cnt = 0;
   int          pass_cnt  = 0;
   int          fail_cnt  = 0;
   int          hs_cnt    = 0;
   logic        hold      = 1'b0;
   logic [31:0] pend_q[$];

   always #5 clk = ~clk;

   rei_fetch #(.Depth(4), .MaxOutstanding(2)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .ibus_arvalid_o (ibus_arvalid),
      .ibus_arready_i (ibus_arready),
      .ibus_araddr_o  (ibus_araddr),
      .ibus_rvalid_i  (ibus_rvalid),
      .ibus_rdata_i   (ibus_rdata),
      .redirect_i     (redirect),
      .redirect_pc_i  (redirect_pc),
      .valid_o        (valid),
      .ready_i        (ready),
      .pc_o           (pc),
      .ir_o           (ir)
   );

   function automatic logic [31:0] ir_of(input logic [31:0] a);
      return a ^ 32'hDEAD_0013;
   endfunction

   // In-order responder: answers each accepted request in the following cycle.
   always @(negedge clk) begin
      if (rst) begin
         pend_q.delete();
         ibus_rvalid = 1'b0;
         ibus_rdata  = 32'h0;
      end else begin
         if (!hold && pend_q.size() != 0) begin
            ibus_rvalid = 1'b1;
            ibus_rdata  = ir_of(pend_q.pop_front());
         end else begin
            ibus_rvalid = 1'b0;
         end
         if (ibus_arvalid && ibus_arready) begin
            pend_q.push_back(ibus_araddr);
            hs_cnt++;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_edge();
      @(posedge clk); #1;
   endtask

   task automatic sample();
      @(negedge clk); #1;
   endtask

   task automatic do_reset();
      drive_edge();
      rst = 1'b1;
      drive_edge();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int          base;
      int          viol;
      logic        seen;
      logic [31:0] first_pc;
      logic [31:0] first_ir;

      rst = 1'b1; ibus_arready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      ready = 1'b0; ibus_rvalid = 1'b0; ibus_rdata = 32'h0;

      // Reset state
      repeat (2) drive_edge();
      sample();
      chk("rst_valid", {31'h0, valid}, 32'h0);
      chk("rst_arvalid", {31'h0, ibus_arvalid}, 32'h0);
      chk("rst_araddr", ibus_araddr, RV);
      chk("rst_pc", pc, 32'h0);
      chk("rst_ir", ir, 32'h0);

      // Streaming: araddr RV, +4, +8...; decode sees them in order after LAT cycles
      drive_edge();
      rst = 1'b0; ibus_arready = 1'b1; ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         sample();
         chk("t1_arvalid", {31'h0, ibus_arvalid}, 32'h1);
         chk("t1_araddr", ibus_araddr, RV + 32'(4 * k));
         if (k < LAT) begin
            chk("t1_valid_low", {31'h0, valid}, 32'h0);
         end else begin
            chk("t1_valid", {31'h0, valid}, 32'h1);
            chk("t1_pc", pc, RV + 32'(4 * (k - LAT)));
            chk("t1_ir", ir, ir_of(RV + 32'(4 * (k - LAT))));
         end
         drive_edge();
      end

      // Back-pressure: exactly Depth requests, then one more per consumed entry
      ready = 1'b0;
      do_reset();
      base = hs_cnt;
      repeat (10) drive_edge();
      sample();
      chk("t2_hs4", 32'(hs_cnt - base), 32'd4);
      chk("t2_arvalid_low", {31'h0, ibus_arvalid}, 32'h0);
      chk("t2_head", pc, RV);
      drive_edge();
      ready = 1'b1;
      sample();
      chk("t2_pop_valid", {31'h0, valid}, 32'h1);
      chk("t2_pop_pc", pc, RV);
      drive_edge();
      ready = 1'b0;
      repeat (6) drive_edge();
      sample();
      chk("t2_hs5", 32'(hs_cnt - base), 32'd5);
      chk("t2_arvalid_low2", {31'h0, ibus_arvalid}, 32'h0);
      chk("t2_head2", pc, RV + 32'd4);

      // Redirect with two requests outstanding: both old responses dropped
      hold = 1'b1; ready = 1'b1;
      do_reset();
      drive_edge();
      drive_edge();
      redirect = 1'b1; redirect_pc = 32'h0000_0100;
      sample();
      chk("t3_arvalid_redir", {31'h0, ibus_arvalid}, 32'h0);
      chk("t3_valid_redir", {31'h0, valid}, 32'h0);
      drive_edge();
      redirect = 1'b0; hold = 1'b0;
      sample();
      chk("t3_empty", {31'h0, valid}, 32'h0);
      seen = 1'b0; first_pc = 32'h0; first_ir = 32'h0;
      for (int k = 0; k < 10 && !seen; k++) begin
         drive_edge();
         sample();
         if (valid) begin
            seen = 1'b1; first_pc = pc; first_ir = ir;
         end
      end
      chk("t3_seen", {31'h0, seen}, 32'h1);
      chk("t3_first_pc", first_pc, 32'h0000_0100);
      chk("t3_first_ir", first_ir, ir_of(32'h0000_0100));

      // Redirect coincident with a response, two outstanding; misaligned target
      hold = 1'b1;
      do_reset();
      drive_edge();
      drive_edge();
      hold = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0202;
      sample();
      chk("t4_valid_redir", {31'h0, valid}, 32'h0);
      drive_edge();
      redirect = 1'b0;
      sample();
      chk("t4_arvalid", {31'h0, ibus_arvalid}, 32'h1);
      chk("t4_araddr", ibus_araddr, 32'h0000_0200);
      chk("t4_valid_low", {31'h0, valid}, 32'h0);
      seen = 1'b0; first_pc = 32'h0; first_ir = 32'h0;
      for (int k = 0; k < 10 && !seen; k++) begin
         drive_edge();
         sample();
         if (valid) begin
            seen = 1'b1; first_pc = pc; first_ir = ir;
         end
      end
      chk("t4_seen", {31'h0, seen}, 32'h1);
      chk("t4_first_pc", first_pc, 32'h0000_0200);
      chk("t4_first_ir", first_ir, ir_of(32'h0000_0200));

      // Redirect while decode is consuming: nothing from the old path retires
      repeat (3) drive_edge();
      drive_edge();
      redirect = 1'b1; redirect_pc = 32'h0000_0301;
      sample();
      chk("t5_valid_redir", {31'h0, valid}, 32'h0);
      drive_edge();
      redirect = 1'b0;
      seen = 1'b0; first_pc = 32'h0; viol = 0;
      for (int k = 0; k < 12; k++) begin
         sample();
         if (valid && ready) begin
            if (!seen) first_pc = pc;
            seen = 1'b1;
            if (pc < 32'h0000_0300) viol++;
         end
         drive_edge();
      end
      chk("t5_seen", {31'h0, seen}, 32'h1);
      chk("t5_first_pc", first_pc, 32'h0000_0300);
      chk("t5_old_path", 32'(viol), 32'h0);

      // Asynchronous reset between clock edges
      sample();
      chk("t6_pre_arvalid", {31'h0, ibus_arvalid}, 32'h1);
      rst = 1'b1;
      #1;
      chk("t6_valid_low", {31'h0, valid}, 32'h0);
      chk("t6_arvalid_low", {31'h0, ibus_arvalid}, 32'h0);
      drive_edge();
      drive_edge();
      rst = 1'b0;
      sample();
      chk("t6_araddr", ibus_araddr, RV);
      chk("t6_arvalid", {31'h0, ibus_arvalid}, 32'h1);
      chk("t6_valid", {31'h0, valid}, 32'h0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
